// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundle of the requester handshakes and memory-side bus
// seen by mem_port_arbiter.
//   fetch side : if_req/if_addr in, if_gnt/if_rvalid/if_rdata out
//   data side  : d_req/d_addr/d_wren/d_wdata/d_funct3 in, d_gnt/d_rvalid/d_rdata out
//   memory side: mem_address/mem_wren/mem_data_in/mem_funct3 out, mem_data_out in
//   status     : busy out
// The arbiter connects through the slave modport; the requesters and memory
// (or a testbench standing in for them) connect through the master modport.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        d_req;
    logic [31:0] d_addr;
    logic        d_wren;
    logic [31:0] d_wdata;
    logic [2:0]  d_funct3;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic [31:0] mem_address;
    logic        mem_wren;
    logic [31:0] mem_data_in;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_data_out;

    logic        busy;

    modport slave (
        input  if_req, if_addr, d_req, d_addr, d_wren, d_wdata, d_funct3, mem_data_out,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_address, mem_wren, mem_data_in, mem_funct3, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_addr, d_wren, d_wdata, d_funct3, mem_data_out,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_address, mem_wren, mem_data_in, mem_funct3, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and
// load/store. One access at a time: grant in IDLE (combinational), hold the
// latched request on the memory bus for MEM_LATENCY cycles (WAIT), then a
// one-cycle response (RESP). Data has priority; after STARVE_LIMIT consecutive
// data grants with fetch waiting, fetch wins the next arbitration.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - mem_port_arbiter_if.slave (requesters, memory, busy)
module mem_port_arbiter #(
    parameter int MEM_LATENCY  = 1,   // 1..7
    parameter int STARVE_LIMIT = 4    // 1..15
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    localparam logic [2:0] LAT_LAST = 3'(MEM_LATENCY - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;     // 1 = data, 0 = fetch
    logic [3:0]  starve_q, starve_d;
    logic [2:0]  lat_q, lat_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        wren_q, wren_d;

    logic data_win, grant;

    // Data wins unless fetch has been passed over STARVE_LIMIT times in a row.
    assign data_win = bus.d_req && !(bus.if_req && starve_q == STARVE_MAX);
    // Gate with reset so no grant escapes while reset is held.
    assign grant    = reset && (state_q == IDLE) && (bus.if_req || bus.d_req);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            starve_q <= '0;
            lat_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= 3'b010;
            wren_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            lat_q    <= lat_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            wren_q   <= wren_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        lat_d    = lat_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        wren_d   = wren_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = WAIT;
                    lat_d   = '0;
                    owner_d = data_win;
                    if (data_win) begin
                        addr_d   = bus.d_addr;
                        wren_d   = bus.d_wren;
                        wdata_d  = bus.d_wdata;
                        funct3_d = bus.d_funct3;
                        // Only count passes while fetch is actually waiting.
                        if (!bus.if_req)
                            starve_d = '0;
                        else if (starve_q != STARVE_MAX)
                            starve_d = starve_q + 4'd1;
                    end else begin
                        addr_d   = bus.if_addr;
                        wren_d   = 1'b0;
                        wdata_d  = '0;
                        funct3_d = 3'b010;
                        starve_d = '0;
                    end
                end
            end
            WAIT: begin
                if (lat_q == LAT_LAST)
                    state_d = RESP;
                else
                    lat_d = lat_q + 3'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic in_acc, resp;
    assign in_acc = (state_q != IDLE);
    assign resp   = (state_q == RESP);

    assign bus.if_gnt      = grant && !data_win;
    assign bus.d_gnt       = grant && data_win;
    assign bus.if_rvalid   = resp && !owner_q;
    assign bus.d_rvalid    = resp && owner_q;
    assign bus.if_rdata    = bus.if_rvalid ? bus.mem_data_out : 32'd0;
    assign bus.d_rdata     = (bus.d_rvalid && !wren_q) ? bus.mem_data_out : 32'd0;
    // Memory bus is parked at zero in IDLE; a store strobes wren only once.
    assign bus.mem_address = in_acc ? addr_q  : 32'd0;
    assign bus.mem_data_in = in_acc ? wdata_q : 32'd0;
    assign bus.mem_funct3  = in_acc ? funct3_q : 3'b010;
    assign bus.mem_wren    = (state_q == WAIT) && (lat_q == 3'd0) && wren_q;
    assign bus.busy        = in_acc;
endmodule
